// File: rtl/crypto_ex_unit.sv
// crypto_ex_unit
//   Multi-cycle scalar-crypto unit for the EX stage. Executes the SHA-256
//   sigma/sum operations (1 cycle) and the RV32 AES32 byte-wise
//   encrypt/decrypt operations (SboxLatency + 2 cycles) behind a
//   start/valid/ready handshake. All outputs are registered.
//
//   Build option: define RISCV_CRYPTO_AES_EN to include the AES datapath.
//   Without it, ops 4-7 complete in one cycle with result 0 and illegal_o=1.
//
// Parameters
//   SboxLatency  S-box cycles (1 or 2); 2 registers the S-box after the input
//                basis change. Ignored when AES is compiled out.
//   LogicGating  1: operands into the SHA/AES datapaths are ANDed with the
//                op enable to suppress toggling.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   en_i         start pulse (accepted in IDLE, or in DONE with ready_id_i)
//   op_i         0 SIG0, 1 SIG1, 2 SUM0, 3 SUM1, 4 ESI, 5 ESMI, 6 DSI, 7 DSMI
//   bs_i         AES byte select
//   operand_a_i  rs1
//   operand_b_i  rs2
//   ready_id_i   ID stage consumes the result this cycle
//   kill_i       flush, abandons any operation (highest priority)
//   result_o     registered result
//   valid_o      result_o is valid
//   busy_o       unit not in IDLE
//   illegal_o    completed op is unsupported (qualified by valid_o)
module crypto_ex_unit #(
    parameter int SboxLatency = 1,
    parameter bit LogicGating = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [2:0]  op_i,
    input  logic [1:0]  bs_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        ready_id_i,
    input  logic        kill_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        illegal_o
);

    typedef enum logic [1:0] {IDLE, SBOX, MIX, DONE} state_e;
    state_e state;

    function automatic logic [31:0] ror32(logic [31:0] v, int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [31:0] sha_f(logic [1:0] sel, logic [31:0] v);
        logic [31:0] r;
        case (sel)
            2'd0:    r = ror32(v, 7)  ^ ror32(v, 18) ^ (v >> 3);
            2'd1:    r = ror32(v, 17) ^ ror32(v, 19) ^ (v >> 10);
            2'd2:    r = ror32(v, 2)  ^ ror32(v, 13) ^ ror32(v, 22);
            default: r = ror32(v, 6)  ^ ror32(v, 11) ^ ror32(v, 25);
        endcase
        return r;
    endfunction

    // A new op is taken in IDLE, or in DONE when the current result is consumed.
    logic accept;
    assign accept = !kill_i && en_i && ((state == IDLE) || (state == DONE && ready_id_i));

    logic [31:0] sha_a, sha_res;
    assign sha_a   = LogicGating ? (operand_a_i & {32{accept && !op_i[2]}}) : operand_a_i;
    assign sha_res = sha_f(op_i[1:0], sha_a);

`ifdef RISCV_CRYPTO_AES_EN
    function automatic logic [7:0] xtime(logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(logic [7:0] x, logic [7:0] y);
        logic [7:0] p, t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(logic [7:0] v);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = v;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(logic [7:0] v);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(logic [7:0] v);
        return {v[6:0], v[7]} ^ {v[4:0], v[7:5]} ^ {v[1:0], v[7:2]} ^ 8'h05;
    endfunction

    logic [31:0] a_q;
    logic [1:0]  bs_q;
    logic [1:0]  aop_q;     // [1]: decrypt, [0]: mix-column variant
    logic [7:0]  x_q, s1_q, y_q;
    logic        cnt_q;

    logic [7:0] x_raw, x_sel;
    always_comb begin
        case (bs_i)
            2'd0:    x_raw = operand_b_i[7:0];
            2'd1:    x_raw = operand_b_i[15:8];
            2'd2:    x_raw = operand_b_i[23:16];
            default: x_raw = operand_b_i[31:24];
        endcase
    end
    assign x_sel = LogicGating ? (x_raw & {8{accept && op_i[2]}}) : x_raw;

    // Input basis change (inverse affine for decrypt), optional register,
    // then field inversion and output affine (encrypt only).
    logic [7:0] s1, s2_in, s2_inv, y;
    assign s1     = aop_q[1] ? inv_affine(x_q) : x_q;
    assign s2_in  = (SboxLatency == 2) ? s1_q : s1;
    assign s2_inv = gf_inv(s2_in);
    assign y      = aop_q[1] ? s2_inv : affine(s2_inv);

    logic [31:0] m, m_rot;
    always_comb begin
        case (aop_q)
            2'd1:    m = {gf_mul(8'h03, y_q), y_q, y_q, gf_mul(8'h02, y_q)};
            2'd3:    m = {gf_mul(8'h0b, y_q), gf_mul(8'h0d, y_q),
                          gf_mul(8'h09, y_q), gf_mul(8'h0e, y_q)};
            default: m = {24'h0, y_q};
        endcase
        case (bs_q)
            2'd0:    m_rot = m;
            2'd1:    m_rot = {m[23:0], m[31:24]};
            2'd2:    m_rot = {m[15:0], m[31:16]};
            default: m_rot = {m[7:0],  m[31:8]};
        endcase
    end
`else
    logic unused_aes_inputs;
    assign unused_aes_inputs = ^{bs_i, operand_b_i};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            result_o  <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            illegal_o <= 1'b0;
`ifdef RISCV_CRYPTO_AES_EN
            a_q   <= '0;
            bs_q  <= '0;
            aop_q <= '0;
            x_q   <= '0;
            s1_q  <= '0;
            y_q   <= '0;
            cnt_q <= 1'b0;
`endif
        end else if (kill_i) begin
            state     <= IDLE;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        busy_o <= 1'b1;
                        if (!op_i[2]) begin
                            result_o  <= sha_res;
                            valid_o   <= 1'b1;
                            illegal_o <= 1'b0;
                            state     <= DONE;
                        end else begin
`ifdef RISCV_CRYPTO_AES_EN
                            a_q       <= operand_a_i;
                            bs_q      <= bs_i;
                            aop_q     <= op_i[1:0];
                            x_q       <= x_sel;
                            cnt_q     <= 1'b0;
                            valid_o   <= 1'b0;
                            illegal_o <= 1'b0;
                            state     <= SBOX;
`else
                            result_o  <= '0;
                            valid_o   <= 1'b1;
                            illegal_o <= 1'b1;
                            state     <= DONE;
`endif
                        end
                    end else if (state == DONE && ready_id_i) begin
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end
                end
`ifdef RISCV_CRYPTO_AES_EN
                SBOX: begin
                    if (SboxLatency == 2 && !cnt_q) begin
                        s1_q  <= s1;
                        cnt_q <= 1'b1;
                    end else begin
                        y_q   <= y;
                        state <= MIX;
                    end
                end
                MIX: begin
                    result_o <= a_q ^ m_rot;
                    valid_o  <= 1'b1;
                    state    <= DONE;
                end
`else
                SBOX, MIX: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_ex_unit.sv
module tb_crypto_ex_unit;

    logic        clk = 1'b0;
    logic        rst, en, ready, kill;
    logic [2:0]  op;
    logic [1:0]  bs;
    logic [31:0] a, b;
    logic [31:0] res;
    logic        valid, busy, ill;

    always #5 clk = ~clk;

    crypto_ex_unit #(.SboxLatency(1), .LogicGating(1)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .op_i(op), .bs_i(bs),
        .operand_a_i(a), .operand_b_i(b), .ready_id_i(ready), .kill_i(kill),
        .result_o(res), .valid_o(valid), .busy_o(busy), .illegal_o(ill)
    );

`ifdef RISCV_CRYPTO_AES_EN
    logic [31:0] res2;
    logic        valid2, busy2, ill2;
    crypto_ex_unit #(.SboxLatency(2), .LogicGating(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .op_i(op), .bs_i(bs),
        .operand_a_i(a), .operand_b_i(b), .ready_id_i(ready), .kill_i(kill),
        .result_o(res2), .valid_o(valid2), .busy_o(busy2), .illegal_o(ill2)
    );
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  bs;
        int          lat;
        logic [31:0] res;
        logic        ill;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(string n, logic [2:0] o, logic [31:0] va, logic [31:0] vb,
                                logic [1:0] vbs, int l, logic [31:0] r, logic il);
        vec_t v;
        v.name = n; v.op = o; v.a = va; v.b = vb; v.bs = vbs; v.lat = l; v.res = r; v.ill = il;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // en_i while busy must only happen as a DONE+ready back-to-back accept.
    always @(posedge clk) begin
        if (!rst && !kill)
            assert (!(en && busy && !(valid && ready))) else begin
                failures++;
                $display("FAIL en_while_busy t=%0t", $time);
            end
    end

    task automatic run_vec(vec_t v);
        int cyc;
        op = v.op; a = v.a; b = v.b; bs = v.bs; en = 1'b1;
        step();
        en = 1'b0;
        a = 32'hdeadbeef; b = 32'hcafef00d; bs = ~v.bs;  // operands must be latched
        cyc = 1;
        while (!valid && cyc < 12) begin
            step();
            cyc++;
        end
        chk({v.name, "_lat"},  cyc, v.lat);
        chk({v.name, "_res"},  res, v.res);
        chk({v.name, "_ill"},  {31'b0, ill}, {31'b0, v.ill});
        chk({v.name, "_busy"}, {31'b0, busy}, 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk({v.name, "_vld_drop"},  {31'b0, valid}, 32'd0);
        chk({v.name, "_busy_drop"}, {31'b0, busy},  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; ready = 1'b0; kill = 1'b0;
        op = '0; bs = '0; a = '0; b = '0;

        add("sig0_1",    3'd0, 32'h00000001, 32'h0, 2'd0, 1, 32'h02004000, 1'b0);
        add("sig1_1",    3'd1, 32'h00000001, 32'h0, 2'd0, 1, 32'h0000a000, 1'b0);
        add("sum0_1",    3'd2, 32'h00000001, 32'h0, 2'd0, 1, 32'h40080400, 1'b0);
        add("sum1_1",    3'd3, 32'h00000001, 32'h0, 2'd0, 1, 32'h04200080, 1'b0);
        add("sig0_msb",  3'd0, 32'h80000000, 32'h0, 2'd0, 1, 32'h11002000, 1'b0);
        add("sig1_msb",  3'd1, 32'h80000000, 32'h0, 2'd0, 1, 32'h00205000, 1'b0);
        add("sum0_ones", 3'd2, 32'hffffffff, 32'h0, 2'd0, 1, 32'hffffffff, 1'b0);
        add("sig0_ones", 3'd0, 32'hffffffff, 32'h0, 2'd0, 1, 32'h1fffffff, 1'b0);
        add("sig1_ones", 3'd1, 32'hffffffff, 32'h0, 2'd0, 1, 32'h003fffff, 1'b0);
        add("sum1_zero", 3'd3, 32'h00000000, 32'h0, 2'd0, 1, 32'h00000000, 1'b0);
`ifdef RISCV_CRYPTO_AES_EN
        add("esi_bs0",   3'd4, 32'h00000000, 32'h00000000, 2'd0, 3, 32'h00000063, 1'b0);
        add("esi_bs1",   3'd4, 32'h00000000, 32'h00000000, 2'd1, 3, 32'h00006300, 1'b0);
        add("esi_bs2",   3'd4, 32'h00000000, 32'h00010000, 2'd2, 3, 32'h007c0000, 1'b0);
        add("esmi_ones", 3'd5, 32'hffffffff, 32'h00000000, 2'd0, 3, 32'h5a9c9c39, 1'b0);
        add("esmi_bs3",  3'd5, 32'h00000000, 32'h01000000, 2'd3, 3, 32'hf8847c7c, 1'b0);
        add("dsi_0",     3'd6, 32'h12345678, 32'h00000000, 2'd0, 3, 32'h1234562a, 1'b0);
        add("dsi_63",    3'd6, 32'h00000000, 32'h00000063, 2'd0, 3, 32'h00000000, 1'b0);
        add("dsi_bs1",   3'd6, 32'hffffffff, 32'h00007c00, 2'd1, 3, 32'hfffffeff, 1'b0);
        add("dsmi_0",    3'd7, 32'h00000000, 32'h00000000, 2'd0, 3, 32'h50a7f451, 1'b0);
        add("dsmi_bs2",  3'd7, 32'h00000000, 32'h00000000, 2'd2, 3, 32'hf45150a7, 1'b0);
`else
        add("ill_esi",   3'd4, 32'h12345678, 32'h11111111, 2'd0, 1, 32'h00000000, 1'b1);
        add("ill_esmi",  3'd5, 32'hffffffff, 32'h0, 2'd1, 1, 32'h00000000, 1'b1);
        add("ill_dsi",   3'd6, 32'h00000001, 32'h0, 2'd2, 1, 32'h00000000, 1'b1);
        add("ill_dsmi",  3'd7, 32'h80000000, 32'h0, 2'd3, 1, 32'h00000000, 1'b1);
`endif

        // Reset state
        step(); step();
        chk("rst_res",   res, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_busy",  {31'b0, busy},  32'd0);
        chk("rst_ill",   {31'b0, ill},   32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // SIG0 held in DONE for three cycles without ready
        op = 3'd0; a = 32'h1; en = 1'b1;
        step();
        en = 1'b0;
        chk("hold_first_valid", {31'b0, valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            step();
            chk("hold_res",   res, 32'h02004000);
            chk("hold_valid", {31'b0, valid}, 32'd1);
            chk("hold_busy",  {31'b0, busy},  32'd1);
        end

        // Back-to-back accept of SUM1 in DONE
        ready = 1'b1; en = 1'b1; op = 3'd3; a = 32'h1;
        step();
        en = 1'b0;
        chk("b2b_valid", {31'b0, valid}, 32'd1);
        chk("b2b_busy",  {31'b0, busy},  32'd1);
        chk("b2b_res",   res, 32'h04200080);
        step();
        ready = 1'b0;
        chk("b2b_idle", {31'b0, busy}, 32'd0);

`ifdef RISCV_CRYPTO_AES_EN
        // Kill while in SBOX: valid never rises
        op = 3'd4; a = 32'h0; b = 32'h0; bs = 2'd0; en = 1'b1;
        step();
        en = 1'b0;
        chk("kill_in_sbox_busy", {31'b0, busy}, 32'd1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_busy",  {31'b0, busy},  32'd0);
        chk("kill_valid", {31'b0, valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("kill_no_valid", {31'b0, valid}, 32'd0);
        end

        // SboxLatency=2 instance: 4-cycle latency
        rst = 1'b1; step(); rst = 1'b0; step();
        begin
            int cyc;
            op = 3'd4; a = 32'h0; b = 32'h0; bs = 2'd0; en = 1'b1;
            step();
            en = 1'b0;
            cyc = 1;
            while (!valid2 && cyc < 12) begin
                step();
                cyc++;
            end
            chk("lat2_cycles", cyc, 32'd4);
            chk("lat2_res",    res2, 32'h00000063);
            chk("lat2_ill",    {31'b0, ill2}, 32'd0);
            ready = 1'b1; step(); ready = 1'b0;
        end
`else
        // Kill while in DONE
        op = 3'd0; a = 32'h1; en = 1'b1;
        step();
        en = 1'b0;
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_busy",  {31'b0, busy},  32'd0);
        chk("kill_valid", {31'b0, valid}, 32'd0);

        // Unsupported op then reset in DONE
        op = 3'd5; a = 32'hffffffff; en = 1'b1;
        step();
        en = 1'b0;
        chk("op5_valid", {31'b0, valid}, 32'd1);
        chk("op5_ill",   {31'b0, ill},   32'd1);
        chk("op5_res",   res, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("op5_rst_valid", {31'b0, valid}, 32'd0);
        chk("op5_rst_ill",   {31'b0, ill},   32'd0);
        chk("op5_rst_busy",  {31'b0, busy},  32'd0);
`endif

        // Reset in DONE also clears a nonzero result
        op = 3'd0; a = 32'h1; en = 1'b1;
        step();
        en = 1'b0;
        chk("pre_rst_res", res, 32'h02004000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_res",   res, 32'h0);
        chk("mid_rst_valid", {31'b0, valid}, 32'd0);
        chk("mid_rst_busy",  {31'b0, busy},  32'd0);
        chk("mid_rst_ill",   {31'b0, ill},   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crypto_ex_unit.md
# crypto_ex_unit

Multi-cycle scalar-crypto functional unit in the EX stage, next to the ALU and multiplier/divider. It executes the SHA-256 sigma/sum operations and the RV32 AES32 byte-wise encrypt/decrypt operations behind a start/valid/ready handshake. The result is registered, replacing the purely combinational SHA-2 path. The S-box latency is parametrised for timing closure, and the whole AES datapath can be compiled out.

## Interface
- `SboxLatency`, default 1: S-box cycles (1 or 2). 2 adds a pipeline register inside the S-box, after the input basis change.
- `LogicGating`, default 1: when 1, operands into the SHA/AES datapaths are ANDed with the op-enable to suppress toggling.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `en_i` in 1: start pulse. Sampled only in IDLE, or in DONE together with `ready_id_i`.
- `op_i` in 3: 0 SIG0, 1 SIG1, 2 SUM0, 3 SUM1, 4 ESI, 5 ESMI, 6 DSI, 7 DSMI.
- `bs_i` in 2: AES byte select.
- `operand_a_i` in 32: rs1.
- `operand_b_i` in 32: rs2.
- `ready_id_i` in 1: ID stage consumes the result this cycle.
- `kill_i` in 1: flush; abandons any operation.
- `result_o` out 32: registered result.
- `valid_o` out 1: `result_o` is valid.
- `busy_o` out 1: unit is not in IDLE.
- `illegal_o` out 1: the completed op is unsupported. Qualified by `valid_o`.

## Operation
- FSM states: IDLE, SBOX, MIX, DONE.
- IDLE, start with SHA op: compute combinationally from `operand_a_i`, register the result, go to DONE.
- IDLE, start with AES op: latch `operand_a_i`, `bs_i`, `op_i` and byte `x = operand_b_i[8*bs+7:8*bs]`, then go to SBOX.
- SBOX: counts `SboxLatency` cycles. ESI/ESMI use the forward S-box; DSI/DSMI use the inverse S-box. Output `y`. Then go to MIX.
- MIX: form word `m`.
  - ESI: `m = {0,0,0,y}`.
  - ESMI: `m = {3y,y,y,2y}` (byte 3 first).
  - DSI: `m = {0,0,0,y}`.
  - DSMI: `m = {Bh*y,Dh*y,9h*y,Eh*y}`.
  - GF(2^8) products use polynomial 11Bh.
  - Register `result = rs1 ^ rotl32(m, 8*bs)`, then go to DONE.
- SHA ops:
  - SIG0 = ror7 ^ ror18 ^ srl3.
  - SIG1 = ror17 ^ ror19 ^ srl10.
  - SUM0 = ror2 ^ ror13 ^ ror22.
  - SUM1 = ror6 ^ ror11 ^ ror25.
- DONE: `valid_o=1`; `result_o` is held stable until `ready_id_i`.
  - On `ready_id_i` without `en_i`: go to IDLE.
  - On `ready_id_i` with `en_i`: start the new op directly, same as the IDLE start.
- `kill_i` in any state: go to IDLE next cycle, `valid_o=0`, latched state discarded. `kill_i` has priority over `en_i` and `ready_id_i`.
- `en_i` in SBOX/MIX, or in DONE without `ready_id_i`: ignored. The bench flags this with an assertion.

## Timing
- Reset: state=IDLE; `result_o`, `valid_o`, `busy_o`, `illegal_o` all 0. Reset applied mid-operation behaves like `kill_i` and also clears `result_o`.
- SHA latency: `valid_o` rises 1 cycle after `en_i`.
- AES latency: `valid_o` rises `SboxLatency + 2` cycles after `en_i` (3 cycles at default).
- `busy_o` is 1 from the cycle after accept until the cycle after the `ready_id_i` handshake. It stays 1 through a back-to-back accept.
- Throughput with `ready_id_i` held high:
  - SHA: one result per cycle.
  - AES: one result per `SboxLatency + 2` cycles.
- No combinational path from any input to any output.

## Configuration
- Macro: `RISCV_CRYPTO_AES_EN`.
- Defined: AES ops, the S-box/inverse S-box and the MIX logic are present. `illegal_o` is always 0.
- Undefined:
  - No AES logic is synthesised and the SBOX/MIX states are unreachable.
  - Ops 4-7 complete like SHA ops, in 1 cycle, with `result_o=0` and `illegal_o=1`.
  - `SboxLatency` is ignored.

## Test plan
- SIG0, a=00000001h -> `valid_o` 1 cycle later, result 02004000h. Hold `ready_id_i=0` for 3 cycles -> result held stable, `busy_o=1`.
- ESI, a=0, b=0, bs=0 -> 00000063h after 3 cycles. Repeat with bs=1 -> 00006300h. Repeat with `SboxLatency=2` -> latency 4 cycles.
- ESMI, a=FFFFFFFFh, b=0, bs=0 -> FFFFFFFFh ^ A56363C6h = 5A9C9C39h.
- DSI, a=12345678h, b=00000000h, bs=0 -> inverse S-box(00h)=52h, result 1234562Ah.
- Back-to-back: SUM1 is accepted in DONE with `ready_id_i=1` and `en_i=1` -> no idle gap. Then `kill_i` pulsed in SBOX -> `valid_o` never rises and the unit is IDLE next cycle.
- Without `RISCV_CRYPTO_AES_EN`: op=5 -> 1 cycle, `result_o=0`, `illegal_o=1`. Then `rst_i` asserted in DONE -> all outputs 0 next cycle.
